// File: rtl/adc_scan_reader.sv
// adc_scan_reader: SPI ADC front end that scans an enabled-channel mask in
// ascending order and returns each conversion tagged with its channel.
// Optional build macro: ADC_SCAN_AVG4_EN (four conversions per channel,
// the reported sample is their truncated average).
//
// state  | meaning
// S_IDLE | CS high, tick counter parked at 0, waiting for start
// S_FRAME| CS low, one FRAME_P-period command/data frame in progress
// S_GAP  | CS high for one ADC clock period between frames
module adc_scan_reader #(
    parameter int CLK_DIV = 500,
    parameter int DATA_W  = 12,
    parameter int NUM_CH  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [NUM_CH-1:0] ch_mask,
    input  logic              continuous,
    input  logic              P4,
    output logic              CS,
    output logic              P3,
    output logic              P5,
    output logic              busy,
    output logic [DATA_W-1:0] sample,
    output logic [2:0]        sample_ch,
    output logic              sample_valid,
    output logic              frame_done
);
    localparam int FRAME_P = 7 + DATA_W;
    localparam int HALF    = CLK_DIV / 2;
    localparam int SAMP    = 3 * CLK_DIV / 4;
    localparam int TICK_W  = $clog2(CLK_DIV);
    localparam int PER_W   = $clog2(FRAME_P);

    typedef enum logic [1:0] {S_IDLE, S_FRAME, S_GAP} state_t;

    state_t              state_q, state_d;
    logic [TICK_W-1:0]   tick_q, tick_d;
    logic [PER_W-1:0]    per_q, per_d;
    logic [2:0]          ch_q, ch_d;
    logic [NUM_CH-1:0]   mask_q, mask_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic [DATA_W-1:0]   sample_q, sample_d;
    logic [2:0]          sample_ch_q, sample_ch_d;
    logic                valid_q, valid_d;
    logic                done_q, done_d;
    logic                cs_q, cs_d;
    logic                p3_q, p3_d;
    logic                p5_q, p5_d;

    logic                tick_end;
    logic [TICK_W-1:0]   tick_next;
    logic [DATA_W-1:0]   shift_in;
    logic                nxt_found, first_found;
    logic [2:0]          nxt_ch, first_ch;
    logic                last_conv;

`ifdef ADC_SCAN_AVG4_EN
    logic [1:0]          conv_q, conv_d;
    logic [DATA_W+1:0]   acc_q, acc_d;
    logic [DATA_W+1:0]   sum;
    assign last_conv = (conv_q == 2'd3);
`else
    assign last_conv = 1'b1;
`endif

    // Lowest enabled channel above the current one, and lowest in the live mask input.
    always_comb begin
        nxt_found   = 1'b0;
        nxt_ch      = '0;
        first_found = 1'b0;
        first_ch    = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask_q[i] && (i > int'(ch_q))) begin
                nxt_found = 1'b1;
                nxt_ch    = 3'(i);
            end
            if (ch_mask[i]) begin
                first_found = 1'b1;
                first_ch    = 3'(i);
            end
        end
    end

    // Next-state, datapath and registered pin values.
    always_comb begin
        state_d     = state_q;
        tick_d      = tick_q;
        per_d       = per_q;
        ch_d        = ch_q;
        mask_d      = mask_q;
        shift_d     = shift_q;
        sample_d    = sample_q;
        sample_ch_d = sample_ch_q;
        valid_d     = 1'b0;
        done_d      = 1'b0;
`ifdef ADC_SCAN_AVG4_EN
        conv_d      = conv_q;
        acc_d       = acc_q;
        sum         = '0;
`endif
        tick_end  = (tick_q == TICK_W'(CLK_DIV - 1));
        tick_next = tick_end ? '0 : tick_q + TICK_W'(1);
        shift_in  = (shift_q << 1) | DATA_W'(P4);

        case (state_q)
            S_IDLE: begin
                if (start && first_found) begin
                    state_d = S_FRAME;
                    tick_d  = '0;
                    per_d   = '0;
                    ch_d    = first_ch;
                    mask_d  = ch_mask;
`ifdef ADC_SCAN_AVG4_EN
                    conv_d  = '0;
                    acc_d   = '0;
`endif
                end
            end
            S_FRAME: begin
                tick_d = tick_next;
                if ((tick_q == TICK_W'(SAMP)) && (per_q >= PER_W'(7))) begin
                    shift_d = shift_in;
                    if (per_q == PER_W'(FRAME_P - 1)) begin
`ifdef ADC_SCAN_AVG4_EN
                        sum = acc_q + (DATA_W + 2)'(shift_in);
                        if (last_conv) begin
                            sample_d = sum[DATA_W+1:2];
                            acc_d    = '0;
                        end else begin
                            acc_d    = sum;
                        end
`else
                        sample_d = shift_in;
`endif
                        if (last_conv) begin
                            valid_d     = 1'b1;
                            sample_ch_d = ch_q;
                            done_d      = !nxt_found;
                        end
                    end
                end
                if (tick_end) begin
                    if (per_q == PER_W'(FRAME_P - 1)) begin
                        state_d = S_GAP;
                        per_d   = '0;
                    end else begin
                        per_d   = per_q + PER_W'(1);
                    end
                end
            end
            S_GAP: begin
                tick_d = tick_next;
                if (tick_end) begin
                    if (!last_conv) begin
                        state_d = S_FRAME;
`ifdef ADC_SCAN_AVG4_EN
                        conv_d  = conv_q + 2'd1;
`endif
                    end else if (nxt_found) begin
                        state_d = S_FRAME;
                        ch_d    = nxt_ch;
`ifdef ADC_SCAN_AVG4_EN
                        conv_d  = '0;
`endif
                    end else if (continuous && first_found) begin
                        state_d = S_FRAME;
                        ch_d    = first_ch;
                        mask_d  = ch_mask;
`ifdef ADC_SCAN_AVG4_EN
                        conv_d  = '0;
`endif
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Pins are registered from the next-state view so they never glitch.
        cs_d = (state_d != S_FRAME);
        p3_d = (state_d != S_IDLE) && (tick_d >= TICK_W'(HALF));
        p5_d = 1'b0;
        if (state_d == S_FRAME) begin
            case (int'(per_d))
                0, 1:    p5_d = 1'b1;
                2:       p5_d = ch_d[2];
                3:       p5_d = ch_d[1];
                4:       p5_d = ch_d[0];
                default: p5_d = 1'b0;
            endcase
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            tick_q      <= '0;
            per_q       <= '0;
            ch_q        <= '0;
            mask_q      <= '0;
            shift_q     <= '0;
            sample_q    <= '0;
            sample_ch_q <= '0;
            valid_q     <= 1'b0;
            done_q      <= 1'b0;
            cs_q        <= 1'b1;
            p3_q        <= 1'b0;
            p5_q        <= 1'b0;
`ifdef ADC_SCAN_AVG4_EN
            conv_q      <= '0;
            acc_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            tick_q      <= tick_d;
            per_q       <= per_d;
            ch_q        <= ch_d;
            mask_q      <= mask_d;
            shift_q     <= shift_d;
            sample_q    <= sample_d;
            sample_ch_q <= sample_ch_d;
            valid_q     <= valid_d;
            done_q      <= done_d;
            cs_q        <= cs_d;
            p3_q        <= p3_d;
            p5_q        <= p5_d;
`ifdef ADC_SCAN_AVG4_EN
            conv_q      <= conv_d;
            acc_q       <= acc_d;
`endif
        end
    end

    assign CS           = cs_q;
    assign P3           = p3_q;
    assign P5           = p5_q;
    assign busy         = (state_q != S_IDLE);
    assign sample       = sample_q;
    assign sample_ch    = sample_ch_q;
    assign sample_valid = valid_q;
    assign frame_done   = done_q;

endmodule

// File: tb/tb_adc_scan_reader.sv
// Bench for adc_scan_reader: an SPI ADC slave model answers each frame with a
// per-channel value, and the recorded results are compared with expectations
// built from the scan rules (ascending set bits, fixed slot timing).
`timescale 1ns/1ps
module tb_adc_scan_reader;
    localparam int D       = 20;
    localparam int W       = 12;
    localparam int N       = 8;
    localparam int FRAME_P = 7 + W;
    localparam int SLOT    = (FRAME_P + 1) * D;
    localparam int FIRST   = 1 + (FRAME_P - 1) * D + 3 * D / 4 + 1;
`ifdef ADC_SCAN_AVG4_EN
    localparam int NCONV = 4;
`else
    localparam int NCONV = 1;
`endif

    logic          clk = 1'b0, rst = 1'b1, start = 1'b0, continuous = 1'b0, P4 = 1'b0;
    logic [N-1:0]  ch_mask = '0;
    logic          CS, P3, P5, busy, sample_valid, frame_done;
    logic [W-1:0]  sample;
    logic [2:0]    sample_ch;

    adc_scan_reader #(.CLK_DIV(D), .DATA_W(W), .NUM_CH(N)) dut (
        .clk(clk), .rst(rst), .start(start), .ch_mask(ch_mask),
        .continuous(continuous), .P4(P4), .CS(CS), .P3(P3), .P5(P5),
        .busy(busy), .sample(sample), .sample_ch(sample_ch),
        .sample_valid(sample_valid), .frame_done(frame_done)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int c; int ch; int val; bit fd; } rec_t;
    rec_t got_q[$];
    int   dec_q[$];
    int   stray_fd = 0, cs_low_cycles = 0, busy_fall = 0, hdr_bad = 0;
    logic busy_prev = 1'b0;
    int   chan_val [N];
    int   off [4] = '{0, 1, 2, 4};
    int   vectors = 0, miscompares = 0;

    // Result recorder, sampled mid-cycle.
    always @(negedge clk) begin
        if (sample_valid) got_q.push_back('{cyc, int'(sample_ch), int'(sample), frame_done});
        if (frame_done && !sample_valid) stray_fd++;
        if (!CS) cs_low_cycles++;
        if (busy_prev && !busy) busy_fall = cyc;
        busy_prev = busy;
    end

    // ADC slave model: reads command on SCLK rise, shifts data out on SCLK fall.
    initial begin
        int rises, frames_seen, dec_ch, q;
        logic [W-1:0] word;
        logic pending, p3_prev;
        rises = 0; frames_seen = 0; dec_ch = 0; word = '0; pending = 1'b0; p3_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                rises = 0; frames_seen = 0; P4 = 1'b0;
            end else if (CS) begin
                rises = 0;
            end else begin
                if (P3 && !p3_prev) begin
                    if (rises <= 1) begin
                        if (P5 !== 1'b1) hdr_bad++;
                        dec_ch = 0;
                    end else if (rises <= 4) begin
                        dec_ch = dec_ch * 2 + int'(P5);
                        if (rises == 4) begin
                            dec_q.push_back(dec_ch);
                            word = W'(chan_val[dec_ch] + ((NCONV == 4) ? off[frames_seen % 4] : 0));
                            frames_seen++;
                        end
                    end else if (P5 !== 1'b0) begin
                        hdr_bad++;
                    end
                    q = rises + 1;
                    pending = (q >= 7 && q <= 6 + W) ? word[W - 1 - (q - 7)] : 1'b0;
                    rises++;
                end
                if (!P3 && p3_prev) P4 = pending;
            end
            p3_prev = P3;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int exp_val(input int v);
        if (NCONV == 4) return (v + (v + 1) + (v + 2) + (v + 4)) >> 2;
        return v;
    endfunction

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", busy, 0);
        @(negedge clk);
    endtask

    task automatic do_start(input logic [N-1:0] m, input bit cont, output int t);
        got_q.delete();
        dec_q.delete();
        @(negedge clk);
        ch_mask = m; continuous = cont; start = 1'b1; t = cyc;
        @(negedge clk);
        start = 1'b0;
        check("cs_low_after_start", CS, 0);
        check("busy_after_start", busy, 1);
    endtask

    task automatic compare_run(input int t, input logic [N-1:0] m, input int nscans);
        int k, top, nset;
        k = 0; top = 0; nset = 0;
        for (int i = 0; i < N; i++) if (m[i]) begin top = i; nset++; end
        check("n_valid", got_q.size(), nset * nscans);
        for (int s = 0; s < nscans; s++)
            for (int i = 0; i < N; i++)
                if (m[i]) begin
                    if (k < got_q.size()) begin
                        check("valid_cycle", got_q[k].c - t, FIRST + (k * NCONV + NCONV - 1) * SLOT);
                        check("sample_ch", got_q[k].ch, i);
                        check("sample", got_q[k].val, exp_val(chan_val[i]));
                        check("frame_done", got_q[k].fd, (i == top) ? 1 : 0);
                    end
                    k++;
                end
        check("busy_fall", busy_fall - t, 1 + nscans * nset * NCONV * SLOT);
        check("adc_frames", dec_q.size(), nscans * nset * NCONV);
        k = 0;
        for (int s = 0; s < nscans; s++)
            for (int i = 0; i < N; i++)
                if (m[i])
                    for (int c = 0; c < NCONV; c++) begin
                        if (k < dec_q.size()) check("adc_cmd_ch", dec_q[k], i);
                        k++;
                    end
        check("cmd_bits", hdr_bad, 0);
        check("stray_frame_done", stray_fd, 0);
    endtask

    task automatic run_scan(input logic [N-1:0] m);
        int t;
        do_start(m, 1'b0, t);
        wait_idle(2 * N * NCONV * SLOT + 100);
        compare_run(t, m, 1);
    endtask

    initial begin
        int t, cs0;
        logic [N-1:0] m;
        for (int i = 0; i < N; i++) chan_val[i] = 0;

        // Reset values while rst is held.
        repeat (3) @(negedge clk);
        check("rst_cs", CS, 1);
        check("rst_p3", P3, 0);
        check("rst_p5", P5, 0);
        check("rst_busy", busy, 0);
        check("rst_sample", sample, 0);
        check("rst_sample_ch", sample_ch, 0);
        check("rst_valid", sample_valid, 0);
        check("rst_frame_done", frame_done, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single channel 0 returning 12'hA5C.
        chan_val[0] = 12'hA5C;
        run_scan(8'h01);

        // Three channels, value = 16*ch.
        for (int i = 0; i < N; i++) chan_val[i] = 16 * i;
        run_scan(8'h94);

        // Randomised masks and values.
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < N; i++) chan_val[i] = $urandom_range(0, 4091);
            m = N'($urandom_range(1, 255));
            run_scan(m);
        end

        // Continuous scan; mask dropped during the second scan.
        chan_val[0] = $urandom_range(0, 4091);
        chan_val[1] = $urandom_range(0, 4091);
        do_start(8'h03, 1'b1, t);
        wait_until(t + 1 + 2 * NCONV * SLOT + 10);
        ch_mask = '0;
        wait_idle(6 * NCONV * SLOT);
        continuous = 1'b0;
        compare_run(t, 8'h03, 2);

        // start with an empty mask is ignored.
        got_q.delete();
        cs0 = cs_low_cycles;
        @(negedge clk);
        ch_mask = '0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        check("zero_mask_busy", busy, 0);
        check("zero_mask_cs", cs_low_cycles - cs0, 0);
        check("zero_mask_valid", got_q.size(), 0);

        // start while busy, including the last busy cycle, is ignored.
        chan_val[0] = 12'h3C7;
        do_start(8'h01, 1'b0, t);
        wait_until(t + 100);
        ch_mask = 8'hFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_until(t + NCONV * SLOT);
        check("busy_last_cycle", busy, 1);
        ch_mask = 8'hFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_boundary_start", busy, 0);
        repeat (2 * D) @(negedge clk);
        check("no_restart_busy", busy, 0);
        compare_run(t, 8'h01, 1);

        // Reset in the middle of period 10 of a frame.
        do_start(8'h01, 1'b0, t);
        wait_until(t + 1 + 10 * D + D / 2 + 2);
        check("pre_rst_cs", CS, 0);
        check("pre_rst_p3", P3, 1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_cs", CS, 1);
        check("midrst_p3", P3, 0);
        check("midrst_p5", P5, 0);
        check("midrst_busy", busy, 0);
        check("midrst_sample", sample, 0);
        check("midrst_sample_ch", sample_ch, 0);
        rst = 1'b0;
        repeat (2 * SLOT) @(negedge clk);
        check("midrst_no_valid", got_q.size(), 0);
        check("midrst_idle", busy, 0);

        // Fresh random scan after reset, then the averaging reference case.
        for (int i = 0; i < N; i++) chan_val[i] = $urandom_range(0, 4091);
        run_scan(N'($urandom_range(1, 255)));
        chan_val[0] = 100;
        run_scan(8'h01);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
